// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: stage indices and controller state.
package pipe_pkg;

    localparam int unsigned STG_PC      = 0;
    localparam int unsigned STG_IF_ID   = 1;
    localparam int unsigned STG_ID_EXE  = 2;
    localparam int unsigned STG_EXE_MEM = 3;
    localparam int unsigned STG_MEM_WB  = 4;
    localparam int unsigned STG_WB      = 5;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_stall_mask.sv
// Priority stall mask: the highest requesting stage freezes itself and every
// older stage, and a bubble is inserted into the register just after it.
module pipe_stall_mask #(
    parameter int unsigned NUM_STAGES = 6
) (
    input  logic [NUM_STAGES-1:0] stallreq,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush
);

    for (genvar j = 0; j < NUM_STAGES; j++) begin : g_stall
        assign stall[j] = |stallreq[NUM_STAGES-1:j];
    end

    assign flush[0] = 1'b0;

    // Bubble sits exactly at the boundary between stalled and running stages.
    for (genvar j = 1; j < NUM_STAGES; j++) begin : g_flush
        assign flush[j] = stall[j-1] & ~stall[j];
    end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush/redirect/halt controller.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl_gen
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 6,
    parameter int unsigned REDIRECT_STAGE = 3,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_STAGES-1:0] stallreq_i,
    input  logic                  redirect_en_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    input  logic                  halt_req_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  pc_load_o,
    output logic [ADDR_WIDTH-1:0] new_pc_o,
    output logic                  halt_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           stall_cycles_o,
    output logic [31:0]           redirect_cnt_o
`endif
);

    localparam int unsigned CNT_W = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1;
    // Registers between PC and the branch-resolving stage hold wrong-path work.
    localparam logic [NUM_STAGES-1:0] REDIR_MASK =
        NUM_STAGES'((64'd1 << REDIRECT_STAGE) - 64'd2);

    pipe_state_e           state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  pend_valid, pend_valid_n;
    logic [ADDR_WIDTH-1:0] pend_addr, pend_addr_n;
    logic [NUM_STAGES-1:0] mask_stall, mask_flush;

    pipe_stall_mask #(
        .NUM_STAGES (NUM_STAGES)
    ) u_stall_mask (
        .stallreq (stallreq_i),
        .stall    (mask_stall),
        .flush    (mask_flush)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_RUN;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pend_valid <= pend_valid_n;
            pend_addr  <= pend_addr_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        pend_valid_n = pend_valid;
        pend_addr_n  = pend_addr;
        unique case (state)
            ST_RUN: begin
                if (halt_req_i) begin
                    state_n      = ST_DRAIN;
                    cnt_n        = CNT_W'(NUM_STAGES - 1);
                    pend_valid_n = 1'b0;
                end else if (pc_load_o) begin
                    pend_valid_n = 1'b0;
                end else if (redirect_en_i) begin
                    pend_valid_n = 1'b1;
                    pend_addr_n  = redirect_addr_i;
                end
            end
            ST_DRAIN: begin
                if (!stall_o[STG_IF_ID]) begin
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        state_n = ST_HALTED;
                    end
                end
            end
            default: begin
                state_n = ST_HALTED;
            end
        endcase
    end

    // Outputs are gated by reset so they read zero while rst_i is low.
    always_comb begin
        stall_o   = '0;
        flush_o   = '0;
        pc_load_o = 1'b0;
        new_pc_o  = '0;
        halt_o    = 1'b0;
        if (rst_i) begin
            unique case (state)
                ST_RUN: begin
                    stall_o = mask_stall;
                    flush_o = mask_flush;
                    if (redirect_en_i) begin
                        flush_o = flush_o | REDIR_MASK;
                        stall_o = stall_o & ~REDIR_MASK;
                    end
                    if (!stall_o[STG_PC] && !halt_req_i) begin
                        if (redirect_en_i) begin
                            pc_load_o = 1'b1;
                            new_pc_o  = redirect_addr_i;
                        end else if (pend_valid) begin
                            pc_load_o = 1'b1;
                            new_pc_o  = pend_addr;
                        end
                    end
                end
                ST_DRAIN: begin
                    stall_o            = mask_stall;
                    stall_o[STG_PC]    = 1'b1;
                    flush_o            = mask_flush;
                    flush_o[STG_IF_ID] = 1'b1;
                end
                default: begin
                    stall_o = '1;
                    halt_o  = 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cycles_o <= '0;
            redirect_cnt_o <= '0;
        end else begin
            if (state == ST_RUN && stall_o[STG_PC]) begin
                stall_cycles_o <= stall_cycles_o + 32'd1;
            end
            if (pc_load_o) begin
                redirect_cnt_o <= redirect_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Self-checking bench for pipe_ctrl_gen: directed scenarios plus random traffic
// compared against a behavioural model of the controller rules.
module tb_pipe_ctrl_gen;

    localparam int N = 6;
    localparam int R = 3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [5:0]  stallreq;
    logic        redirect_en;
    logic [31:0] redirect_addr;
    logic        halt_req;
    logic [5:0]  stall_o;
    logic [5:0]  flush_o;
    logic        pc_load_o;
    logic [31:0] new_pc_o;
    logic        halt_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_o;
    logic [31:0] redirect_cnt_o;
`endif

    pipe_ctrl_gen #(
        .NUM_STAGES     (N),
        .REDIRECT_STAGE (R),
        .ADDR_WIDTH     (32)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .stallreq_i      (stallreq),
        .redirect_en_i   (redirect_en),
        .redirect_addr_i (redirect_addr),
        .halt_req_i      (halt_req),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .pc_load_o       (pc_load_o),
        .new_pc_o        (new_pc_o),
        .halt_o          (halt_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles_o  (stall_cycles_o),
        .redirect_cnt_o  (redirect_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int halted_for = 0;

    // Model state: mode 0 = running, 1 = draining, 2 = halted.
    int          m_mode = 0;
    int          m_left = 0;
    bit          m_pv   = 1'b0;
    logic [31:0] m_pa   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model_out(input logic [5:0] sreq, input logic red,
                                      input logic [31:0] addr, input logic hlt,
                                      output logic [5:0] es, output logic [5:0] ef,
                                      output logic epl, output logic [31:0] enp,
                                      output logic eh);
        int k;
        logic [5:0] rmask;
        k = -1;
        for (int i = 0; i < N; i++) if (sreq[i]) k = i;
        rmask = 6'(((1 << R) - 1) & ~1);
        es  = (k >= 0) ? 6'((1 << (k + 1)) - 1) : 6'd0;
        ef  = (k >= 0 && k + 1 < N) ? 6'(1 << (k + 1)) : 6'd0;
        epl = 1'b0;
        enp = '0;
        eh  = 1'b0;
        if (m_mode == 0) begin
            if (red) begin
                ef = ef | rmask;
                es = es & ~rmask;
            end
            if (!es[0] && !hlt) begin
                if (red) begin
                    epl = 1'b1;
                    enp = addr;
                end else if (m_pv) begin
                    epl = 1'b1;
                    enp = m_pa;
                end
            end
        end else if (m_mode == 1) begin
            es = es | 6'd1;
            ef = ef | 6'd2;
        end else begin
            es = 6'h3f;
            ef = 6'h00;
            eh = 1'b1;
        end
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_pv   = 1'b0;
        m_pa   = '0;
        halted_for = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stall"},   32'(stall_o),   32'd0);
        check({tag, "_flush"},   32'(flush_o),   32'd0);
        check({tag, "_pc_load"}, 32'(pc_load_o), 32'd0);
        check({tag, "_new_pc"},  new_pc_o,       32'd0);
        check({tag, "_halt"},    32'(halt_o),    32'd0);
    endtask

    // Entered at posedge+1; reset asserts immediately (async) and releases after one edge.
    task automatic do_reset();
        rst_i = 1'b0;
        #1;
        check_zero("reset_async");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("reset_held");
        rst_i = 1'b1;
    endtask

    // Entered at posedge+1: drive, check at negedge, advance model at posedge.
    task automatic step(input string tag, input logic [5:0] sreq, input logic red,
                        input logic [31:0] addr, input logic hlt);
        logic [5:0]  es, ef;
        logic        epl, eh;
        logic [31:0] enp;
        stallreq      = sreq;
        redirect_en   = red;
        redirect_addr = addr;
        halt_req      = hlt;
        model_out(sreq, red, addr, hlt, es, ef, epl, enp, eh);
        @(negedge clk);
        check({tag, "_stall"},   32'(stall_o),   32'(es));
        check({tag, "_flush"},   32'(flush_o),   32'(ef));
        check({tag, "_pc_load"}, 32'(pc_load_o), 32'(epl));
        check({tag, "_new_pc"},  new_pc_o,       enp);
        check({tag, "_halt"},    32'(halt_o),    32'(eh));
        @(posedge clk);
        if (m_mode == 0) begin
            if (hlt) begin
                m_mode = 1;
                m_left = N - 1;
                m_pv   = 1'b0;
            end else if (epl) begin
                m_pv = 1'b0;
            end else if (red) begin
                m_pv = 1'b1;
                m_pa = addr;
            end
        end else if (m_mode == 1) begin
            if (!es[1]) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end
        end
        halted_for = (m_mode == 2) ? halted_for + 1 : 0;
        #1;
    endtask

    initial begin
        logic [5:0] sreq;
        stallreq      = 6'b000100;
        redirect_en   = 1'b1;
        redirect_addr = 32'h55;
        halt_req      = 1'b0;
        rst_i         = 1'b0;
        #1;
        check_zero("por");
        @(posedge clk);
        #1;
        do_reset();

        step("stall_k2", 6'b000100, 1'b0, 32'h0, 1'b0);
        step("idle", 6'b000000, 1'b0, 32'h0, 1'b0);
        step("redirect", 6'b000000, 1'b1, 32'h80, 1'b0);
        step("redir_stalled", 6'b010000, 1'b1, 32'h80, 1'b0);
        step("pend_hold", 6'b010000, 1'b0, 32'h0, 1'b0);
        step("pend_load", 6'b000000, 1'b0, 32'h0, 1'b0);
        check("pend_load_addr_direct", new_pc_o, 32'h0);
        step("after_pend", 6'b000000, 1'b0, 32'h0, 1'b0);
        step("pend_latch", 6'b000001, 1'b1, 32'h40, 1'b0);
        step("live_over_pend", 6'b000000, 1'b1, 32'h99, 1'b0);
        step("pend_gone", 6'b000000, 1'b0, 32'h0, 1'b0);
        step("top_stall", 6'b100000, 1'b0, 32'h0, 1'b0);

        // Halt wins over a simultaneous redirect, then drains and halts.
        step("halt_redir", 6'b000000, 1'b1, 32'h44, 1'b1);
        for (int i = 0; i < 5; i++) step("drain", 6'b000000, 1'b1, 32'h12, 1'b1);
        for (int i = 0; i < 3; i++) step("halted", 6'b001000, 1'b1, 32'h12, 1'b0);
        do_reset();

        // Drain with stalls on IF/ID, then abort via reset.
        step("halt2", 6'b000000, 1'b0, 32'h0, 1'b1);
        step("drain_stall1", 6'b000010, 1'b0, 32'h0, 1'b0);
        step("drain_stall3", 6'b001000, 1'b0, 32'h0, 1'b0);
        step("drain_free", 6'b000000, 1'b0, 32'h0, 1'b0);
        do_reset();
        step("run_after_abort", 6'b000100, 1'b0, 32'h0, 1'b0);

        // Reset while a redirect is pending must drop it.
        step("pend_before_rst", 6'b000001, 1'b1, 32'hABC, 1'b0);
        do_reset();
        step("no_pend_after_rst", 6'b000000, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            sreq = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            step("rand", sreq, 1'($urandom_range(0, 3) == 0), $urandom,
                 1'($urandom_range(0, 39) == 0));
            if (halted_for > 3 || (m_mode == 1 && $urandom_range(0, 9) == 0)) do_reset();
        end

`ifdef PIPE_CTRL_PERF_EN
        do_reset();
        for (int i = 0; i < 3; i++) step("perf_stall", 6'b000001, 1'b0, 32'h0, 1'b0);
        step("perf_redir1", 6'b000000, 1'b1, 32'h100, 1'b0);
        step("perf_redir2", 6'b000000, 1'b1, 32'h200, 1'b0);
        check("stall_cycles", stall_cycles_o, 32'd3);
        check("redirect_cnt", redirect_cnt_o, 32'd2);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_gen.md
PIPE_CTRL_GEN -- requirements
Module: pipe_ctrl_gen

Interface
REQ-001 The block SHALL have parameter NUM_STAGES, default 6, giving the number of pipeline registers; index 0 is PC, 1 is IF/ID, and the highest index is WB.
REQ-002 The block SHALL have parameter REDIRECT_STAGE, default 3, giving the index of the register fed by the branch-resolving stage.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 32, giving the PC width.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port stallreq_i, input, NUM_STAGES bits: per-stage stall request; bit k is driven by the logic feeding register k.
REQ-007 The block SHALL have port redirect_en_i, input, 1 bit: taken jump or branch.
REQ-008 The block SHALL have port redirect_addr_i, input, ADDR_WIDTH bits: jump target.
REQ-009 The block SHALL have port halt_req_i, input, 1 bit: halt pulse from the MEM stage.
REQ-010 The block SHALL have port stall_o, output, NUM_STAGES bits: 1 freezes register k.
REQ-011 The block SHALL have port flush_o, output, NUM_STAGES bits: 1 loads a NOP bubble into register k.
REQ-012 The block SHALL have port pc_load_o, output, 1 bit: the PC loads new_pc_o.
REQ-013 The block SHALL have port new_pc_o, output, ADDR_WIDTH bits: the redirect target.
REQ-014 The block SHALL have port halt_o, output, 1 bit: the pipeline is drained and halted.

Function
REQ-015 The block SHALL implement the states RUN, DRAIN and HALTED; stall_o, flush_o and pc_load_o SHALL be combinational from the inputs and the registered state (0-cycle latency).
REQ-016 In RUN, with k the highest asserted stallreq_i bit, the block SHALL drive stall_o[j]=1 for all j≤k and flush_o[k+1]=1 when k+1<NUM_STAGES; with no request, stall_o SHALL be 0.
REQ-017 In RUN, on redirect_en_i, the block SHALL drive flush_o[1..REDIRECT_STAGE-1]=1; flush SHALL override stall for these bits.
REQ-018 A redirect with stall_o[0]=0 SHALL produce pc_load_o=1 and new_pc_o=redirect_addr_i in the same cycle.
REQ-019 A redirect with stall_o[0]=1 SHALL latch the target into a pending register; on the first cycle with stall_o[0]=0 the block SHALL drive pc_load_o=1 from the pending register and then clear it.
REQ-020 A new redirect SHALL overwrite the pending target; the live input SHALL take priority over the pending target when both apply in the same cycle.
REQ-021 halt_req_i in RUN SHALL move the state to DRAIN, clear any pending redirect and load the drain counter with NUM_STAGES-1.
REQ-022 In DRAIN the block SHALL:
- hold stall_o[0]=1 and flush_o[1]=1;
- apply the REQ-016 stall rules above index 0;
- decrement the counter only on cycles with stall_o[1]=0;
- ignore redirect_en_i and halt_req_i.
REQ-023 When the counter reaches 0 the state SHALL move to HALTED, where stall_o is all 1s, flush_o=0 and halt_o=1; only reset leaves HALTED.
REQ-024 halt_req_i and redirect_en_i asserted in the same RUN cycle SHALL be resolved in favour of the halt: no pc_load_o, but the REQ-017 flush still applies.

Reset
REQ-025 While rst_i=0, the state SHALL be RUN, the pending register and drain counter SHALL be cleared, and stall_o, flush_o, pc_load_o, new_pc_o and halt_o SHALL all be 0.
REQ-026 Reset asserted mid-DRAIN or mid-pending SHALL abort the operation immediately, asynchronously.

Configuration
REQ-027 When PIPE_CTRL_PERF_EN is defined, the block SHALL add outputs stall_cycles_o and redirect_cnt_o, 32 bits each, reset to 0 and wrapping at 2^32-1 to 0.
REQ-028 stall_cycles_o SHALL count RUN cycles with stall_o[0]=1; redirect_cnt_o SHALL count cycles with pc_load_o=1.
REQ-029 When PIPE_CTRL_PERF_EN is undefined, the counter ports and logic SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-030 The shared package pipe_pkg SHALL hold the stage-index constants (STG_PC, STG_IF_ID, STG_ID_EXE, STG_EXE_MEM, STG_MEM_WB, STG_WB) and the state enum.
REQ-031 The priority stall-mask logic (REQ-016) SHALL be a combinational sub-module, pipe_stall_mask, parametrised by NUM_STAGES.

Verification
REQ-032 The bench SHALL cover: rst_i=0 -> stall_o=6'b000000, flush_o=6'b000000, halt_o=0.
REQ-033 The bench SHALL cover: stallreq_i=6'b000100 for 1 cycle -> stall_o=6'b000111, flush_o=6'b001000 in that cycle.
REQ-034 The bench SHALL cover: redirect_en_i=1, redirect_addr_i=0x80, no stall -> pc_load_o=1, new_pc_o=0x80, flush_o=6'b000110.
REQ-035 The bench SHALL cover: redirect to 0x80 with stallreq_i[4]=1 held 2 cycles -> pc_load_o=0 during the stall, then pc_load_o=1 with new_pc_o=0x80 on the first unstalled cycle.
REQ-036 The bench SHALL cover: halt_req_i pulse with no stalls -> 5 DRAIN cycles, then halt_o=1 and stall_o=6'b111111 until reset.
REQ-037 The bench SHALL cover: with PIPE_CTRL_PERF_EN defined, 3 stalled cycles plus 2 redirects -> stall_cycles_o=3, redirect_cnt_o=2.
